// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the memory.
// The controller drives the registered request fields; memory answers with ack/rdata.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one registered request per access,
// stalls the pipeline while the memory is busy, extends load data and
// reports misaligned accesses and bus timeouts.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd_en_in,
  input  logic                  mem_wr_en_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_signed_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  mem_access_ctrl_if.master     dmem,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  load_valid_out,
  output logic                  misaligned_err_out,
  output logic                  bus_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pending, misaligned, issue, timeout, finish;
  logic [1:0]       size_p1;
  logic             signed_p1;
  logic [1:0]       lane_p1;
  logic [CNT_W-1:0] busy_cnt;

  // Little-endian lane enables; size 11 behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data copied into every lane so the memory only needs the byte enables.
  function automatic logic [DATA_WIDTH-1:0] replicate(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] data);
    case (size)
      2'b00:   return {(DATA_WIDTH/8){data[7:0]}};
      2'b01:   return {(DATA_WIDTH/16){data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0] size,
                                                        input logic sgn,
                                                        input logic [1:0] lane,
                                                        input logic [DATA_WIDTH-1:0] rdata);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = rdata >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   return sgn ? DATA_WIDTH'(b) : DATA_WIDTH'(sh[7:0]);
      2'b01:   return sgn ? DATA_WIDTH'(h) : DATA_WIDTH'(sh[15:0]);
      default: return rdata;
    endcase
  endfunction

  assign pending    = mem_rd_en_in | mem_wr_en_in;
  assign misaligned = ((mem_size_in == 2'b01) & addr_in[0]) |
                      (mem_size_in[1] & (|addr_in[1:0]));
  assign timeout    = (busy_cnt == CNT_LAST);
  assign finish     = (state_q == BUSY) & (dmem.dmem_ack | timeout);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and misalignment decode.
  always_comb begin
    state_d            = state_q;
    issue              = 1'b0;
    stall_out          = 1'b0;
    misaligned_err_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending && misaligned) begin
          misaligned_err_out = 1'b1;
        end else if (pending) begin
          issue     = 1'b1;
          stall_out = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (dmem.dmem_ack || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request stage: launch on issue, hold through BUSY, drop on ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
    end else if (issue) begin
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= mem_wr_en_in;
      dmem.dmem_addr  <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
      dmem.dmem_be    <= byte_en(mem_size_in, addr_in[1:0]);
      dmem.dmem_wdata <= replicate(mem_size_in, wr_data_in);
    end else if (finish) begin
      dmem.dmem_req   <= 1'b0;
    end
  end

  // Latched access attributes and BUSY cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_p1   <= '0;
      signed_p1 <= 1'b0;
      lane_p1   <= '0;
      busy_cnt  <= '0;
    end else if (issue) begin
      size_p1   <= mem_size_in;
      signed_p1 <= mem_signed_in;
      lane_p1   <= addr_in[1:0];
      busy_cnt  <= '0;
    end else if (state_q == BUSY && !finish) begin
      busy_cnt  <= busy_cnt + 1'b1;
    end
  end

  // Result stage: one-cycle valid/error pulses in DONE, load data held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
      if (state_q == BUSY && dmem.dmem_ack) begin
        if (!dmem.dmem_we) begin
          load_data_out  <= extend_load(size_p1, signed_p1, lane_p1, dmem.dmem_rdata);
          load_valid_out <= 1'b1;
        end
      end else if (state_q == BUSY && timeout) begin
        load_data_out <= '0;
        bus_err_out   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases followed by randomized accesses
// compared against a byte-lane reference model.
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, rd, wr, sgn;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          stall, lvalid, mis, berr;
  logic [DW-1:0] ldata;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] prev_ld = '0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_rd_en_in(rd), .mem_wr_en_in(wr), .mem_size_in(size), .mem_signed_in(sgn),
    .addr_in(addr), .wr_data_in(wd),
    .dmem(bus),
    .stall_out(stall), .load_data_out(ldata), .load_valid_out(lvalid),
    .misaligned_err_out(mis), .bus_err_out(berr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [AW-1:0] a);
    int n = nbytes(s);
    int off = int'(a[1:0]);
    logic [3:0] e = '0;
    for (int i = 0; i < 4; i++) e[i] = (i >= off) && (i < off + n);
    return e;
  endfunction

  function automatic logic [DW-1:0] m_wdata(input logic [1:0] s, input logic [DW-1:0] d);
    int n = nbytes(s);
    longint unsigned v = 0;
    for (int i = 0; i < 4; i++)
      v = v | (((longint'(d) >> (8 * (i % n))) & 64'hFF) << (8 * i));
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] m_load(input logic [1:0] s, input logic sg,
                                           input logic [AW-1:0] a, input logic [DW-1:0] r);
    int n = nbytes(s);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned v = (longint'(r) >> (8 * int'(a[1:0]))) & mask;
    if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[DW-1:0];
  endfunction

  // One access from an IDLE cycle through DONE and back to IDLE.
  // ack_at: BUSY cycle (1-based) in which ack is given; 0 means never.
  task automatic run_access(input string tag, input logic r, input logic w,
                            input logic [1:0] s, input logic sg, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int ack_at, input logic [DW-1:0] rdat);
    bit pend, misal, acked;
    pend  = r | w;
    misal = pend && ((int'(a[1:0]) % nbytes(s)) != 0);
    rd = r; wr = w; size = s; sgn = sg; addr = a; wd = d;
    #1;
    chk({tag, ".mis"}, 64'(mis), 64'(misal));
    chk({tag, ".stall_idle"}, 64'(stall), 64'(pend && !misal));
    if (!pend || misal) begin
      @(negedge clk);
      chk({tag, ".noreq"}, 64'(bus.dmem_req), 64'd0);
      rd = 1'b0; wr = 1'b0;
      return;
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk({tag, ".req"},  64'(bus.dmem_req), 64'd1);
    chk({tag, ".we"},   64'(bus.dmem_we), 64'(w));
    chk({tag, ".addr"}, 64'(bus.dmem_addr), 64'({a[AW-1:2], 2'b00}));
    chk({tag, ".be"},   64'(bus.dmem_be), 64'(m_be(s, a)));
    if (w) chk({tag, ".wdata"}, 64'(bus.dmem_wdata), 64'(m_wdata(s, d)));
    acked = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) begin
        @(negedge clk);
        chk({tag, ".req_hold"}, 64'(bus.dmem_req), 64'd1);
        chk({tag, ".be_hold"},  64'(bus.dmem_be), 64'(m_be(s, a)));
      end
      chk({tag, ".stall_busy"}, 64'(stall), 64'd1);
      if (k == ack_at) begin
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rdat; acked = 1'b1;
      end else begin
        bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
      end
      if (acked) break;
    end
    @(negedge clk);
    bus.dmem_ack = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    if (acked && !w) prev_ld = m_load(s, sg, a, rdat);
    else if (!acked) prev_ld = '0;
    #1;
    chk({tag, ".done_req"},   64'(bus.dmem_req), 64'd0);
    chk({tag, ".done_stall"}, 64'(stall), 64'd0);
    chk({tag, ".done_valid"}, 64'(lvalid), 64'(acked && !w));
    chk({tag, ".done_berr"},  64'(berr), 64'(!acked));
    chk({tag, ".done_data"},  64'(ldata), 64'(prev_ld));
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk({tag, ".idle_valid"}, 64'(lvalid), 64'd0);
    chk({tag, ".idle_berr"},  64'(berr), 64'd0);
    chk({tag, ".idle_req"},   64'(bus.dmem_req), 64'd0);
    chk({tag, ".idle_data"},  64'(ldata), 64'(prev_ld));
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; size = 2'b00; sgn = 1'b0; addr = '0; wd = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.req",    64'(bus.dmem_req), 64'd0);
    chk("rst.be",     64'(bus.dmem_be), 64'd0);
    chk("rst.addr",   64'(bus.dmem_addr), 64'd0);
    chk("rst.stall",  64'(stall), 64'd0);
    chk("rst.valid",  64'(lvalid), 64'd0);
    chk("rst.berr",   64'(berr), 64'd0);
    chk("rst.data",   64'(ldata), 64'd0);
    chk("rst.mis",    64'(mis), 64'd0);
    rst = 1'b0;

    run_access("sbyte_ld",   1, 0, 2'b00, 1, 32'h0000_1003, 32'h0,         2,  32'h80FF_0000);
    run_access("half_st",    0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 1,  32'h0);
    run_access("mis_word",   1, 0, 2'b10, 0, 32'h0000_3001, 32'h0,         1,  32'h0);
    run_access("mis_half",   0, 1, 2'b01, 0, 32'h0000_3003, 32'h1234,      1,  32'h0);
    run_access("timeout_ld", 1, 0, 2'b10, 0, 32'h0000_5000, 32'h0,         0,  32'hDEAD_BEEF);
    run_access("last_ack",   1, 0, 2'b01, 1, 32'h0000_6002, 32'h0,         TO, 32'h8001_7FFF);
    run_access("rdwr_both",  1, 1, 2'b01, 0, 32'h0000_4000, 32'h0000_1234, 3,  32'hFFFF_FFFF);
    run_access("size11",     1, 0, 2'b11, 0, 32'h0000_7004, 32'h0,         1,  32'h1357_9BDF);
    run_access("no_access",  0, 0, 2'b10, 0, 32'h0000_8000, 32'h0,         1,  32'h0);

    // Reset while a load is in flight; a late ack must not produce a result.
    rd = 1'b1; wr = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h0000_9000;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    prev_ld = '0;
    chk("rstbusy.req",   64'(bus.dmem_req), 64'd0);
    chk("rstbusy.stall", 64'(stall), 64'd0);
    chk("rstbusy.data",  64'(ldata), 64'd0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("lateack.valid", 64'(lvalid), 64'd0);
    chk("lateack.req",   64'(bus.dmem_req), 64'd0);
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("lateack.valid2", 64'(lvalid), 64'd0);
    chk("lateack.berr",   64'(berr), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic          r_r, r_w, r_sg;
      logic [1:0]    r_s;
      logic [AW-1:0] r_a;
      int            r_ack;
      r_r   = 1'($urandom_range(0, 1));
      r_w   = 1'($urandom_range(0, 1));
      r_sg  = 1'($urandom_range(0, 1));
      r_s   = 2'($urandom_range(0, 3));
      r_a   = $urandom;
      if ($urandom_range(0, 3) != 0) r_a[1:0] = r_a[1:0] & ~2'(nbytes(r_s) - 1);
      r_ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      run_access("rand", r_r, r_w, r_s, r_sg, r_a, $urandom, r_ack, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles to wait for dmem_ack.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- mem_rd_en_in, in, 1, MEM-stage instruction is a load.
- mem_wr_en_in, in, 1, MEM-stage instruction is a store.
- mem_size_in, in, 2, access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_signed_in, in, 1, sign-extend load result.
- addr_in, in, ADDR_WIDTH, byte address (ALU result).
- wr_data_in, in, DATA_WIDTH, store data, right-aligned.
- dmem_req, out, 1, memory request, registered.
- dmem_we, out, 1, request is a write, registered.
- dmem_addr, out, ADDR_WIDTH, word-aligned address (bits [1:0] = 0), registered.
- dmem_be, out, 4, byte enables, registered.
- dmem_wdata, out, DATA_WIDTH, lane-replicated store data, registered.
- dmem_ack, in, 1, memory completes the request this cycle.
- dmem_rdata, in, DATA_WIDTH, read data, valid when dmem_ack = 1.
- stall_out, out, 1, freeze the pipeline upstream of MEM.
- load_data_out, out, DATA_WIDTH, extended load result.
- load_valid_out, out, 1, load_data_out is valid this cycle.
- misaligned_err_out, out, 1, misaligned access detected.
- bus_err_out, out, 1, access timed out.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-004 Access pending = mem_rd_en_in | mem_wr_en_in; when both are high, the access SHALL be a write.
REQ-005 Misalignment SHALL be detected for half access with addr_in[0] = 1 and for word access with addr_in[1:0] != 0.
REQ-006 In IDLE, a pending aligned access SHALL, at the next edge:
- enter BUSY;
- assert dmem_req;
- set dmem_we, dmem_addr, dmem_be and dmem_wdata;
- latch size, signed flag and addr_in[1:0].
REQ-007 In IDLE, a pending misaligned access SHALL issue no request, hold the FSM in IDLE and keep stall_out low.
REQ-008 misaligned_err_out SHALL be combinational and high exactly in IDLE cycles that see a pending misaligned access.
REQ-009 stall_out SHALL be combinational: high in BUSY, and high in IDLE with a pending aligned access; low in DONE and otherwise.
REQ-010 Byte enables (little-endian) SHALL be:
- byte: 0001 shifted left by addr[1:0];
- half: 0011 (addr[1] = 0) or 1100 (addr[1] = 1);
- word: 1111.
- Loads SHALL use the same dmem_be pattern.
REQ-011 dmem_wdata SHALL replicate the store data across lanes:
- byte: wr_data_in[7:0] in all four lanes;
- half: wr_data_in[15:0] in both halves;
- word: wr_data_in unchanged.
REQ-012 In BUSY, dmem_req and the dmem_* outputs SHALL hold stable until the edge after dmem_ack = 1; that edge SHALL clear dmem_req and enter DONE.
REQ-013 For a load, the ack-cycle dmem_rdata SHALL be captured; load_data_out SHALL be the selected lane, sign- or zero-extended per the latched size/signed flag.
REQ-014 A BUSY cycle counter SHALL:
- reset to 0 on BUSY entry;
- when it reaches TIMEOUT_CYCLES-1 without ack, clear dmem_req at the next edge, enter DONE and flag a bus error.
REQ-015 dmem_ack in the final timeout cycle SHALL take precedence (normal completion).
REQ-016 DONE SHALL last one cycle and then return to IDLE, ignoring inputs.
- load_valid_out = 1 in DONE for a completed load.
- bus_err_out = 1 in DONE after a timeout, with load_data_out = 0 and load_valid_out = 0.
REQ-017 load_valid_out and bus_err_out SHALL be 0 outside DONE; load_data_out SHALL hold its last value outside DONE.
REQ-018 dmem_ack received in IDLE or DONE SHALL be ignored.

Reset
REQ-019 With rst = 1 at a rising edge, the block SHALL enter IDLE and clear all registered outputs, the counter and the latched fields to 0. A request in flight SHALL be abandoned (dmem_req = 0 the following cycle).
REQ-020 Combinational outputs SHALL follow the reset state (stall_out = 0 unless an aligned access is pending in IDLE).

Verification
REQ-021 Signed byte load: addr 0x1003, rdata 0x80FF_0000, ack in 2nd BUSY cycle -> be = 1000, stall for 3 cycles, DONE load_data_out = 0xFFFF_FF80, load_valid_out = 1.
REQ-022 Half store: addr 0x2002, wr_data 0x0000_ABCD -> dmem_addr = 0x2000, be = 1100, wdata = 0xABCD_ABCD, we = 1, no load_valid_out.
REQ-023 Misaligned word load at 0x3001 -> misaligned_err_out = 1, stall_out = 0, dmem_req remains 0.
REQ-024 No ack for 16 BUSY cycles -> dmem_req drops, bus_err_out pulses 1 cycle, load_data_out = 0, return to IDLE.
REQ-025 rst asserted in 2nd BUSY cycle -> next cycle dmem_req = 0, state IDLE; a late ack produces no load_valid_out.
REQ-026 rd and wr both high with a zero-extended half load configured -> a write is issued (we = 1).
